i2c_slave_regs: RTL and testbench
=================================

# i2c_slave_regs

Parametrised I2C slave that exposes a bank of 8-bit registers to an external I2C master. It adds to our first-generation slave:

- a configurable device address and register count;
- a register pointer with auto-increment and wrap;
- repeated-START support;
- double-flop synchronisation of SDA/SCL;
- a simple register-file port toward the core logic.

It sits between the board I2C pins and the design's control/status registers.

## Interface
- DEV_ADDR, 7'h60, 7-bit slave address matched against the first byte.
- NUM_REGS, 8, number of registers; power of two, 2..256.
- PTR_W, $clog2(NUM_REGS), pointer width (derived, not overridden).

Ports:
- CLK  input  1  system clock; must be ≥ 16× SCL frequency.
- RESET  input  1  synchronous, active-high; clock CLK.
- ENB  input  1  module enable; when low, FSM forced to IDLE and SDA released.
- SDA  inout  1  I2C data; driven only as 0 or Z.
- SCL  inout  1  I2C clock; never driven (always Z).
- wr_en  output  1  one-CLK pulse: write wr_data to register wr_addr.
- wr_addr  output  PTR_W  target register of the write.
- wr_data  output  8  received data byte.
- rd_addr  output  PTR_W  current pointer; core returns that register on rd_data.
- rd_data  input  8  register contents, combinational from rd_addr.
- busy  output  1  high from accepted address match until STOP/START/IDLE.

## Operation
- Input conditioning:
  - SDA and SCL pass through two flops (s2) plus one history flop (s3).
  - An SCL rise/fall is flagged when s2 != s3.
  - START = SCL_s2 high while SDA falls. STOP = SCL_s2 high while SDA rises.
  - START and STOP are valid in any state. START goes to ADDR (a repeated start keeps the pointer). STOP goes to IDLE.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- IDLE: SDA released, bit counter cleared; leaves only on START.
- ADDR:
  - Shift in 8 bits on SCL rises, MSB first.
  - At the SCL fall after bit 8: if bits[7:1]==DEV_ADDR, go to ADDR_ACK; otherwise go to WAIT_STOP (no ACK).
- ADDR_ACK:
  - Drive SDA=0 for one SCL period; busy=1.
  - At the following SCL fall: R/W=0 goes to RX_BYTE, with the first-byte flag set.
  - R/W=1: load shift register from rd_data, increment the pointer, go to TX_BYTE.
- RX_BYTE: shift 8 bits. At the SCL fall after bit 8, go to RX_ACK and act on the byte:
  - If it is the first byte: pointer = byte[PTR_W-1:0].
  - Otherwise: wr_en pulse with wr_addr=pointer and wr_data=byte, then pointer++ (wraps NUM_REGS-1→0).
- RX_ACK: drive SDA=0; at the next SCL fall, release SDA and go to RX_BYTE.
- TX_BYTE:
  - Present the shift-register MSB on SDA (0 drives low, 1 releases), updating on each SCL fall.
  - After 8 bits, release SDA and go to TX_ACK.
- TX_ACK:
  - Sample SDA at the SCL rise.
  - ACK (0): at the SCL fall, reload from rd_data, pointer++, go to TX_BYTE.
  - NACK: go to WAIT_STOP.
- WAIT_STOP: SDA released; wait for STOP or START.
- Pointer resets to 0 and persists across transactions.
- General-call address 0x00 is not acknowledged.

## Timing
- Reset values: SDA/SCL Z, wr_en 0, wr_addr 0, wr_data 0, rd_addr 0, busy 0, state IDLE, pointer 0.
- Pin edge → flag detected: 2 CLK cycles. Flag → registered action (state change, SDA drive change, wr_en): +1 CLK. Total: 3 CLK after the SCL pin edge.
- SDA drive changes only in the cycle after a detected SCL fall. It never changes while SCL_s2 is high, so the slave never creates a false START/STOP.
- wr_en is asserted for exactly 1 CLK, coincident with ACK drive start. wr_addr/wr_data are held until the next write.
- rd_data is sampled in the same CLK cycle that the pointer increments. The pointer updates on the next cycle.
- STOP/START arriving mid-byte: partial byte discarded, no wr_en, SDA released within 1 CLK of detection.
- RESET mid-transaction: all of the above reset values apply next cycle; the bus is released.
- ENB deassert: behaves as STOP (state IDLE, SDA released, busy 0); the pointer is kept.

## Test plan
- Write addr 0x60/W, pointer 0x02, data 0xA5, 0x3C → ACK on all 4 bytes; wr_en pulses with (2,0xA5) then (3,0x3C); busy falls on STOP.
- NUM_REGS=8: pointer 0x07, data 0x11, 0x22 → writes (7,0x11), (0,0x22) (wrap); then pointer 0x0B → next write goes to register 3.
- Write pointer 0x05, repeated START, 0x60/R, master ACK, ACK, NACK → SDA bytes equal regs 5,6,7; no wr_en; pointer ends at 0 (8 mod 8).
- Address 0x61/W followed by data 0xFF → SDA never driven low, no wr_en, busy stays 0, returns to IDLE on STOP.
- Write with STOP after 4 data bits of the second data byte → only the first data byte is written; IDLE; SDA Z.
- RESET asserted during TX_BYTE with SDA driven low → SDA Z and all outputs at reset values next CLK. Repeat with ENB low: address 0x60 is not ACKed.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C slave exposing a bank of 8-bit registers to an external master.
// Write transfer: the first data byte loads the register pointer; each later byte is
// written to the pointed register, and the pointer then auto-increments and wraps.
// Read transfer: returns the register at the pointer, then increments the pointer.
// Ports:
//   CLK, RESET   system clock, synchronous active-high reset
//   ENB          module enable; low forces IDLE and releases SDA (pointer kept)
//   SDA, SCL     I2C pins; SDA is only ever pulled low or released, SCL never driven
//   wr_en        one-CLK write strobe with wr_addr / wr_data (held until next write)
//   rd_addr      current register pointer; core answers combinationally on rd_data
//   busy         high from an accepted address match until STOP/START/IDLE
module i2c_slave_regs #(
    parameter logic [6:0]  DEV_ADDR = 7'h60,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned PTR_W   = $clog2(NUM_REGS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    inout  wire              SDA,
    inout  wire              SCL,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    // Pin synchronisers (s1, s2) plus one history stage (s3) for edge detection
    logic sda_s1, sda_s2, sda_s3;
    logic scl_s1, scl_s2, scl_s3;

    logic scl_rise_c, scl_fall_c, start_c, stop_c;

    state_t             state, state_d;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic [7:0]         shreg, shreg_d;
    logic [PTR_W-1:0]   ptr, ptr_d;
    logic               first_byte, first_byte_d;
    logic               mst_ack, mst_ack_d;
    logic               sda_oe, sda_oe_d;
    logic               busy_d;
    logic               wr_en_d;
    logic [PTR_W-1:0]   wr_addr_d;
    logic [7:0]         wr_data_d;

    // Open-drain data pin; SCL is left untouched
    assign SDA     = sda_oe ? 1'b0 : 1'bz;
    assign rd_addr = ptr;

    // Input conditioning; idle bus level is high
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_s3 <= 1'b1;
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_s3 <= 1'b1;
        end else begin
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
            sda_s3 <= sda_s2;
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            scl_s3 <= scl_s2;
        end
    end

    assign scl_rise_c = scl_s2 & ~scl_s3;
    assign scl_fall_c = ~scl_s2 & scl_s3;
    assign start_c    = scl_s2 & sda_s3 & ~sda_s2;
    assign stop_c     = scl_s2 & ~sda_s3 & sda_s2;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ptr        <= '0;
            first_byte <= 1'b0;
            mst_ack    <= 1'b1;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            ptr        <= ptr_d;
            first_byte <= first_byte_d;
            mst_ack    <= mst_ack_d;
            sda_oe     <= sda_oe_d;
            busy       <= busy_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
        end
    end

    // Next-state and output logic; bus conditions override every state
    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        shreg_d      = shreg;
        ptr_d        = ptr;
        first_byte_d = first_byte;
        mst_ack_d    = mst_ack;
        sda_oe_d     = sda_oe;
        busy_d       = busy;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;

        if (!ENB) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_c) begin
            // Also a repeated START: pointer is deliberately preserved
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_c) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                end
                ADDR: begin
                    if (scl_rise_c) begin
                        shreg_d   = {shreg[6:0], sda_s2};
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end else if (scl_fall_c && bit_cnt == CNT_W'(8)) begin
                        bit_cnt_d = '0;
                        // General-call (all-zero) address is never acknowledged
                        if (shreg[7:1] == DEV_ADDR && shreg[7:1] != 7'd0) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_c) begin
                        bit_cnt_d = '0;
                        if (shreg[0]) begin
                            // Read: latch current register, advance pointer, drive MSB now
                            shreg_d  = rd_data;
                            ptr_d    = ptr + PTR_W'(1);
                            sda_oe_d = ~rd_data[7];
                            state_d  = TX_BYTE;
                        end else begin
                            sda_oe_d     = 1'b0;
                            first_byte_d = 1'b1;
                            state_d      = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise_c) begin
                        shreg_d   = {shreg[6:0], sda_s2};
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end else if (scl_fall_c && bit_cnt == CNT_W'(8)) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                        state_d   = RX_ACK;
                        if (first_byte) begin
                            first_byte_d = 1'b0;
                            ptr_d        = shreg[PTR_W-1:0];
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr;
                            wr_data_d = shreg;
                            ptr_d     = ptr + PTR_W'(1);
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall_c) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = RX_BYTE;
                    end
                end
                TX_BYTE: begin
                    // MSB is already on the bus; each fall moves to the next bit
                    if (scl_fall_c) begin
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = TX_ACK;
                        end else begin
                            shreg_d   = {shreg[6:0], 1'b0};
                            sda_oe_d  = ~shreg[6];
                            bit_cnt_d = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise_c) begin
                        mst_ack_d = sda_s2;
                    end else if (scl_fall_c) begin
                        if (!mst_ack) begin
                            shreg_d  = rd_data;
                            ptr_d    = ptr + PTR_W'(1);
                            sda_oe_d = ~rd_data[7];
                            state_d  = TX_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: directed bench for i2c_slave_regs acting as the I2C master
// and as the core-side register file. SCL quarter period is Q CLK cycles.
module tb_i2c_slave_regs;

    localparam int Q = 20;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic        ENB   = 1'b1;
    logic        sda_m = 1'b1;   // 1 = master releases SDA
    logic        scl_m = 1'b1;   // 1 = master releases SCL
    wire         sda_bus;
    wire         scl_bus;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    assign sda_bus = sda_m ? 1'bz : 1'b0;
    assign scl_bus = scl_m ? 1'bz : 1'b0;
    pullup (sda_bus);
    pullup (scl_bus);

    i2c_slave_regs #(.DEV_ADDR(7'h60), .NUM_REGS(8)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ENB     (ENB),
        .SDA     (sda_bus),
        .SCL     (scl_bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;

    // Core register file: reg i resets to {i,i}
    logic [7:0] regs [8];
    assign rd_data = regs[rd_addr];
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) regs[i] <= {4'(i), 4'(i)};
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Bus monitor
    logic [10:0] wlog [$];
    int   wide_cnt = 0;
    int   low_cnt  = 0;
    int   busy_cnt = 0;
    logic wr_en_q  = 1'b0;
    always @(negedge CLK) begin
        if (wr_en) wlog.push_back({wr_addr, wr_data});
        if (wr_en && wr_en_q) wide_cnt++;
        wr_en_q = wr_en;
        if (sda_bus === 1'b0 && sda_m === 1'b1) low_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    int checks = 0;
    int errors = 0;
    int coll   = 0;

    task automatic quarter();
        repeat (Q) @(negedge CLK);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b; quarter();
        scl_m = 1'b1; quarter();
        s = sda_bus; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic start_cond();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(d[i], s);
            if (s !== d[i]) coll++;
        end
        bit_cycle(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(mack, s);
        if (s !== mack) coll++;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0h expected 0", wr_en); end
        checks++; if (wr_addr !== 3'd0) begin errors++; $display("FAIL reset_wr_addr: got %0h expected 0", wr_addr); end
        checks++; if (wr_data !== 8'd0) begin errors++; $display("FAIL reset_wr_data: got %0h expected 0", wr_data); end
        checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda: got %0h expected 1", sda_bus); end
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        int   base = wlog.size();
        int   cb   = coll;
        start_cond();
        send_byte(8'hC0, a0);
        send_byte(8'h02, a1);
        send_byte(8'hA5, a2);
        send_byte(8'h3C, a3);
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL write_acks: got %b expected 0000", {a0, a1, a2, a3}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_before_stop: got %0h expected 1", busy); end
        stop_cond();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %0h expected 0", busy); end
        checks++; if (wlog.size() - base !== 2) begin errors++; $display("FAIL write_count: got %0d expected 2", wlog.size() - base); end
        else begin
            checks++; if (wlog[base] !== {3'd2, 8'hA5}) begin errors++; $display("FAIL write_first: got %0h expected 2a5", wlog[base]); end
            checks++; if (wlog[base+1] !== {3'd3, 8'h3C}) begin errors++; $display("FAIL write_second: got %0h expected 33c", wlog[base+1]); end
        end
        checks++; if (rd_addr !== 3'd4) begin errors++; $display("FAIL write_ptr: got %0h expected 4", rd_addr); end
        checks++; if (coll !== cb) begin errors++; $display("FAIL write_collisions: got %0d expected %0d", coll, cb); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3, b0, b1, b2;
        int   base = wlog.size();
        start_cond();
        send_byte(8'hC0, a0);
        send_byte(8'h07, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        stop_cond();
        start_cond();
        send_byte(8'hC0, b0);
        send_byte(8'h0B, b1);
        send_byte(8'h33, b2);
        stop_cond();
        checks++; if ({a0, a1, a2, a3, b0, b1, b2} !== 7'b0) begin errors++; $display("FAIL wrap_acks: got %b expected 0000000", {a0, a1, a2, a3, b0, b1, b2}); end
        checks++; if (wlog.size() - base !== 3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", wlog.size() - base); end
        else begin
            checks++; if (wlog[base] !== {3'd7, 8'h11}) begin errors++; $display("FAIL wrap_w0: got %0h expected 711", wlog[base]); end
            checks++; if (wlog[base+1] !== {3'd0, 8'h22}) begin errors++; $display("FAIL wrap_w1: got %0h expected 022", wlog[base+1]); end
            checks++; if (wlog[base+2] !== {3'd3, 8'h33}) begin errors++; $display("FAIL wrap_ptr_trunc: got %0h expected 333", wlog[base+2]); end
        end
    endtask

    task automatic test_read();
        logic       a0, a1, a2;
        logic [7:0] d0, d1, d2;
        int         base = wlog.size();
        start_cond();
        send_byte(8'hC0, a0);
        send_byte(8'h05, a1);
        start_cond();
        send_byte(8'hC1, a2);
        recv_byte(1'b0, d0);
        recv_byte(1'b0, d1);
        recv_byte(1'b1, d2);
        stop_cond();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (d0 !== 8'h55) begin errors++; $display("FAIL read_reg5: got %0h expected 55", d0); end
        checks++; if (d1 !== 8'h66) begin errors++; $display("FAIL read_reg6: got %0h expected 66", d1); end
        checks++; if (d2 !== 8'h11) begin errors++; $display("FAIL read_reg7: got %0h expected 11", d2); end
        checks++; if (wlog.size() !== base) begin errors++; $display("FAIL read_no_write: got %0d expected %0d", wlog.size(), base); end
        checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL read_ptr_wrap: got %0h expected 0", rd_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy: got %0h expected 0", busy); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int   base = wlog.size();
        int   lb   = low_cnt;
        int   bb   = busy_cnt;
        start_cond();
        send_byte(8'hC2, a0);
        send_byte(8'hFF, a1);
        stop_cond();
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL wrong_addr_nack: got %b expected 11", {a0, a1}); end
        checks++; if (low_cnt !== lb) begin errors++; $display("FAIL wrong_addr_sda_low: got %0d expected %0d", low_cnt, lb); end
        checks++; if (busy_cnt !== bb) begin errors++; $display("FAIL wrong_addr_busy: got %0d expected %0d", busy_cnt, bb); end
        checks++; if (wlog.size() !== base) begin errors++; $display("FAIL wrong_addr_write: got %0d expected %0d", wlog.size(), base); end
    endtask

    task automatic test_stop_mid_byte();
        logic a0, a1, a2, s;
        int   base = wlog.size();
        start_cond();
        send_byte(8'hC0, a0);
        send_byte(8'h01, a1);
        send_byte(8'h9A, a2);
        bit_cycle(1'b0, s);
        bit_cycle(1'b1, s);
        bit_cycle(1'b1, s);
        bit_cycle(1'b1, s);
        stop_cond();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL mid_stop_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (wlog.size() - base !== 1) begin errors++; $display("FAIL mid_stop_count: got %0d expected 1", wlog.size() - base); end
        else begin
            checks++; if (wlog[base] !== {3'd1, 8'h9A}) begin errors++; $display("FAIL mid_stop_write: got %0h expected 19a", wlog[base]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_stop_busy: got %0h expected 0", busy); end
        checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL mid_stop_sda: got %0h expected 1", sda_bus); end
    endtask

    task automatic test_reset_mid_tx();
        logic a0, a1, a2;
        start_cond();
        send_byte(8'hC0, a0);
        send_byte(8'h00, a1);
        start_cond();
        send_byte(8'hC1, a2);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rst_tx_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (sda_bus !== 1'b0) begin errors++; $display("FAIL rst_tx_sda_driven: got %0h expected 0", sda_bus); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_tx_busy_pre: got %0h expected 1", busy); end
        checks++; if (rd_addr !== 3'd1) begin errors++; $display("FAIL rst_tx_ptr_pre: got %0h expected 1", rd_addr); end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rst_tx_sda: got %0h expected 1", sda_bus); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_tx_busy: got %0h expected 0", busy); end
        checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL rst_tx_rd_addr: got %0h expected 0", rd_addr); end
        checks++; if ({wr_en, wr_addr, wr_data} !== 12'd0) begin errors++; $display("FAIL rst_tx_wr_port: got %0h expected 0", {wr_en, wr_addr, wr_data}); end
        @(negedge CLK);
        RESET = 1'b0;
        stop_cond();
    endtask

    task automatic test_enb_low();
        logic a0;
        int   lb = low_cnt;
        int   bb = busy_cnt;
        ENB = 1'b0;
        start_cond();
        send_byte(8'hC0, a0);
        stop_cond();
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL enb_low_nack: got %0h expected 1", a0); end
        checks++; if (low_cnt !== lb) begin errors++; $display("FAIL enb_low_sda: got %0d expected %0d", low_cnt, lb); end
        checks++; if (busy_cnt !== bb) begin errors++; $display("FAIL enb_low_busy: got %0d expected %0d", busy_cnt, bb); end
        ENB = 1'b1;
        quarter();
    endtask

    task automatic test_back_to_back();
        logic a0, a1, a2;
        int   base = wlog.size();
        start_cond();
        send_byte(8'hC0, a0);
        send_byte(8'h04, a1);
        send_byte(8'h5A, a2);
        stop_cond();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL b2b_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (wlog.size() - base !== 1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", wlog.size() - base); end
        else begin
            checks++; if (wlog[base] !== {3'd4, 8'h5A}) begin errors++; $display("FAIL b2b_write: got %0h expected 45a", wlog[base]); end
        end
        checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL wr_en_width: got %0d wide pulses expected 0", wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrap();
        test_read();
        test_wrong_addr();
        test_stop_mid_byte();
        test_reset_mid_tx();
        test_enb_low();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
